// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module  : io_pkg
// Brief   : Shared op-codes and command FSM encoding for io_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
package io_pkg;

  localparam logic [1:0] IO_OP_ON     = 2'b00;
  localparam logic [1:0] IO_OP_OFF    = 2'b01;
  localparam logic [1:0] IO_OP_TOGGLE = 2'b10;
  localparam logic [1:0] IO_OP_PUSH   = 2'b11;

  typedef enum logic [0:0] {
    IO_ST_IDLE = 1'b0,
    IO_ST_PUSH = 1'b1
  } io_state_e;

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
// Module  : io_debounce
// Brief   : One channel of 2-FF synchroniser, debounce counter and edge pulses.
// Revision: 1.0 - initial release
// ============================================================================
module io_debounce #(
  parameter logic DS  = 1'b0,
  parameter int   DBC = 4,
  parameter int   DBW = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic en,
  output logic state,
  output logic rise,
  output logic fall
);

  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic           state_q, state_d;
  logic           rise_q,  rise_d;
  logic           fall_q,  fall_d;
  logic [DBW-1:0] cnt_q,   cnt_d;

  // The level only moves after DBC consecutive differing synchronised samples.
  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en && (sync2_q != state_q)) begin
      if (cnt_q == DBW'(DBC - 1)) begin
        state_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + DBW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= DS;
      sync2_q <= DS;
      state_q <= DS;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/io_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : io_ctrl
// Brief   : Multi-channel bidirectional IO block: direction register,
//           debounced inputs with edge pulses, ON/OFF/TOGGLE/PUSH outputs.
//           Optional macro IO_IRQ_EN adds sticky edge interrupt status.
// Revision: 1.0 - initial release
// ============================================================================
module io_ctrl
  import io_pkg::*;
#(
  parameter int   SW  = 4,
  parameter logic OE  = 1'b0,
  parameter logic DS  = 1'b0,
  parameter int   PD  = 10,
  parameter int   DBC = 4,
  parameter int   DBW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  inout  wire  [SW-1:0] io,
  input  logic          dir_we,
  input  logic [SW-1:0] dir,
  output logic [SW-1:0] oe,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [SW-1:0] cmd_mask,
  output logic [SW-1:0] o,
  output logic [SW-1:0] in_state,
  output logic [SW-1:0] in_rise,
`ifdef IO_IRQ_EN
  input  logic [SW-1:0] irq_ack,
  output logic [SW-1:0] irq_status,
  output logic          irq,
`endif
  output logic [SW-1:0] in_fall
);

  localparam int PCW = (PD > 1) ? $clog2(PD) : 1;

  io_state_e     state_q, state_d;
  logic [SW-1:0] o_q,     o_d;
  logic [SW-1:0] oe_q,    oe_d;
  logic [SW-1:0] mask_q,  mask_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic          ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    mask_d  = mask_q;
    pcnt_d  = pcnt_q;
    ready_d = ready_q;
    oe_d    = dir_we ? dir : oe_q;
    case (state_q)
      IO_ST_IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            IO_OP_ON:     o_d = DS ? (o_q & ~cmd_mask) : (o_q | cmd_mask);
            IO_OP_OFF:    o_d = DS ? (o_q | cmd_mask) : (o_q & ~cmd_mask);
            IO_OP_TOGGLE: o_d = o_q ^ cmd_mask;
            default: begin
              o_d     = o_q ^ cmd_mask;
              mask_d  = cmd_mask;
              pcnt_d  = PCW'(PD - 1);
              state_d = IO_ST_PUSH;
              ready_d = 1'b0;
            end
          endcase
        end
      end
      default: begin
        // Pulse spans the accept edge plus PD-1 countdown edges: PD cycles total.
        if (pcnt_q == '0) begin
          o_d     = o_q ^ mask_q;
          state_d = IO_ST_IDLE;
          ready_d = 1'b1;
        end else begin
          pcnt_d = pcnt_q - PCW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IO_ST_IDLE;
      o_q     <= {SW{DS}};
      oe_q    <= {SW{OE}};
      mask_q  <= '0;
      pcnt_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      oe_q    <= oe_d;
      mask_q  <= mask_d;
      pcnt_q  <= pcnt_d;
      ready_q <= ready_d;
    end
  end

  assign o         = o_q;
  assign oe        = oe_q;
  assign cmd_ready = ready_q;

  for (genvar n = 0; n < SW; n++) begin : g_chan
    assign io[n] = oe_q[n] ? o_q[n] : 1'bz;

    io_debounce #(
      .DS  (DS),
      .DBC (DBC),
      .DBW (DBW)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (io[n]),
      .en    (~oe_q[n]),
      .state (in_state[n]),
      .rise  (in_rise[n]),
      .fall  (in_fall[n])
    );
  end

`ifdef IO_IRQ_EN
  logic [SW-1:0] irq_status_q, irq_status_d;
  logic          irq_q,        irq_d;

  // A new edge in the same cycle as its acknowledge keeps the bit set.
  always_comb begin
    irq_status_d = (irq_status_q & ~irq_ack) | in_rise | in_fall;
    irq_d        = |irq_status_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_status_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      irq_status_q <= irq_status_d;
      irq_q        <= irq_d;
    end
  end

  assign irq_status = irq_status_q;
  assign irq        = irq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_io_ctrl
// Brief   : Scoreboard bench for io_ctrl (SW=4, DS=0, OE=0, PD=3, DBC=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_io_ctrl;

  localparam int K_O    = 0;
  localparam int K_OE   = 1;
  localparam int K_ST   = 2;
  localparam int K_RISE = 3;
  localparam int K_FALL = 4;
  localparam int K_RDY  = 5;
  localparam int K_IO   = 6;
  localparam int K_IRQS = 7;
  localparam int K_IRQ  = 8;

  localparam logic [1:0] OP_ON = 2'b00, OP_OFF = 2'b01, OP_TGL = 2'b10, OP_PUSH = 2'b11;

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] val;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  wire  [3:0] io;
  logic       dir_we;
  logic [3:0] dir;
  logic [3:0] oe;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [3:0] o;
  logic [3:0] in_state;
  logic [3:0] in_rise;
  logic [3:0] in_fall;
`ifdef IO_IRQ_EN
  logic [3:0] irq_ack;
  logic [3:0] irq_status;
  logic       irq;
`endif

  logic [3:0] tb_en;
  logic [3:0] tb_val;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  exp_t       sb[$];

  for (genvar g = 0; g < 4; g++) begin : g_pin
    assign io[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  io_ctrl #(
    .SW  (4),
    .OE  (1'b0),
    .DS  (1'b0),
    .PD  (3),
    .DBC (4),
    .DBW (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (io),
    .dir_we     (dir_we),
    .dir        (dir),
    .oe         (oe),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_mask   (cmd_mask),
    .o          (o),
    .in_state   (in_state),
    .in_rise    (in_rise),
`ifdef IO_IRQ_EN
    .irq_ack    (irq_ack),
    .irq_status (irq_status),
    .irq        (irq),
`endif
    .in_fall    (in_fall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] sample(int kind);
    case (kind)
      K_O:    return o;
      K_OE:   return oe;
      K_ST:   return in_state;
      K_RISE: return in_rise;
      K_FALL: return in_fall;
      K_RDY:  return {3'b000, cmd_ready};
      K_IO:   return io;
`ifdef IO_IRQ_EN
      K_IRQS: return irq_status;
      K_IRQ:  return {3'b000, irq};
`endif
      default: return 4'bxxxx;
    endcase
  endfunction

  task automatic expect_at(input int dly, input int kind, input logic [3:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + dly;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] mask, input logic [3:0] exp_o, input string name);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    expect_at(1, K_O, exp_o, name);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  // Monitor: compares every expectation that falls due on this cycle.
  always @(negedge clk) begin
    int i;
    logic [3:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        n_checks++;
        act = sample(sb[i].kind);
        if (sb[i].cyc < cyc)
          $display("FAIL %s: not sampled by cycle %0d (expected %b)", sb[i].name, sb[i].cyc, sb[i].val);
        else if (act === sb[i].val)
          n_pass++;
        else
          $display("FAIL %s: got %b expected %b (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    dir_we    = 1'b0;
    dir       = 4'h0;
    cmd_valid = 1'b0;
    cmd_op    = OP_ON;
    cmd_mask  = 4'h0;
    tb_en     = 4'hF;
    tb_val    = 4'h0;
`ifdef IO_IRQ_EN
    irq_ack   = 4'h0;
`endif
    tick(2);
    expect_at(0, K_O,    4'b0000, "rst_o");
    expect_at(0, K_OE,   4'b0000, "rst_oe");
    expect_at(0, K_ST,   4'b0000, "rst_state");
    expect_at(0, K_RDY,  4'b0001, "rst_ready");
    expect_at(0, K_RISE, 4'b0000, "rst_rise");
    rst_n = 1'b1;
    tick(3);

    // Steady rise on io[0]: 2 sync + 4 debounce cycles.
    tb_val = 4'b0001;
    expect_at(5, K_ST,   4'b0000, "db_before");
    expect_at(6, K_ST,   4'b0001, "db_state");
    expect_at(6, K_RISE, 4'b0001, "db_rise");
    expect_at(7, K_RISE, 4'b0000, "db_rise_one_cycle");
    tick(8);

    // 3-cycle glitch on io[1] must be rejected.
    tb_val = 4'b0011;
    tick(3);
    tb_val = 4'b0001;
    for (int k = 1; k <= 8; k++) expect_at(k, K_RISE, 4'b0000, "glitch_rise");
    expect_at(8, K_ST, 4'b0001, "glitch_state");
    tick(9);

    // All channels to output; commands.
    dir_we = 1'b1;
    dir    = 4'hF;
    tb_en  = 4'h0;
    expect_at(1, K_OE, 4'hF, "dir_all_out");
    tick(1);
    dir_we = 1'b0;
    send(OP_ON,  4'b0101, 4'b0101, "cmd_on");
    send(OP_OFF, 4'b0001, 4'b0100, "cmd_off");
    expect_at(1, K_IO, 4'b0111, "io_follows_o");
    expect_at(1, K_ST, 4'b0001, "out_state_held");
    send(OP_TGL, 4'b0011, 4'b0111, "cmd_toggle");
    send(OP_OFF, 4'b1111, 4'b0000, "cmd_off_all");

    // PUSH 1000 for 3 cycles, TOGGLE offered while busy.
    cmd_valid = 1'b1;
    cmd_op    = OP_PUSH;
    cmd_mask  = 4'b1000;
    expect_at(1, K_O,   4'b1000, "push_c1");
    expect_at(2, K_O,   4'b1000, "push_c2");
    expect_at(3, K_O,   4'b1000, "push_c3");
    expect_at(4, K_O,   4'b0000, "push_end");
    expect_at(5, K_O,   4'b0000, "push_toggle_ignored");
    expect_at(1, K_RDY, 4'b0000, "push_busy1");
    expect_at(2, K_RDY, 4'b0000, "push_busy2");
    expect_at(3, K_RDY, 4'b0000, "push_busy3");
    expect_at(4, K_RDY, 4'b0001, "push_ready");
    tick(1);
    cmd_op   = OP_TGL;
    cmd_mask = 4'b0001;
    tick(3);
    cmd_valid = 1'b0;
    tick(2);

    // Direction write and command in the same cycle.
    dir_we    = 1'b1;
    dir       = 4'b0010;
    cmd_valid = 1'b1;
    cmd_op    = OP_TGL;
    cmd_mask  = 4'b0010;
    expect_at(1, K_OE, 4'b0010, "collide_oe");
    expect_at(1, K_O,  4'b0010, "collide_o");
    tick(1);
    dir_we    = 1'b0;
    cmd_valid = 1'b0;
    tb_en     = 4'b1101;
    tb_val    = 4'b0001;
    tick(1);

    // Reset during the second PUSH cycle.
    cmd_valid = 1'b1;
    cmd_op    = OP_PUSH;
    cmd_mask  = 4'b0001;
    expect_at(1, K_O, 4'b0011, "push2_c1");
    tick(1);
    cmd_valid = 1'b0;
    tick(1);
    rst_n  = 1'b0;
    tb_en  = 4'hF;
    tb_val = 4'b0001;
    expect_at(0, K_O,   4'b0000, "async_rst_o");
    expect_at(0, K_OE,  4'b0000, "async_rst_oe");
    expect_at(0, K_ST,  4'b0000, "async_rst_state");
    expect_at(0, K_RDY, 4'b0001, "async_rst_ready");
    tick(1);
    rst_n = 1'b1;
    expect_at(2, K_O,    4'b0000, "push_aborted");
    expect_at(3, K_RDY,  4'b0001, "idle_after_rst");
    expect_at(5, K_O,    4'b0000, "push_no_revert");
    expect_at(6, K_ST,   4'b0001, "rerise_state");
    expect_at(6, K_RISE, 4'b0001, "rerise_pulse");
    tick(8);

`ifdef IO_IRQ_EN
    irq_ack = 4'hF;
    expect_at(1, K_IRQS, 4'b0000, "irq_clear_all");
    expect_at(1, K_IRQ,  4'b0000, "irq_low");
    tick(1);
    irq_ack = 4'h0;
`endif

    // Rise then fall on io[2].
    tb_val = 4'b0101;
    expect_at(6, K_RISE, 4'b0100, "io2_rise");
    expect_at(6, K_ST,   4'b0101, "io2_state_hi");
`ifdef IO_IRQ_EN
    expect_at(7, K_IRQS, 4'b0100, "irq_on_rise");
    expect_at(7, K_IRQ,  4'b0001, "irq_high_rise");
`endif
    tick(8);
`ifdef IO_IRQ_EN
    irq_ack = 4'b0100;
    expect_at(1, K_IRQS, 4'b0000, "irq_ack_clean1");
    expect_at(1, K_IRQ,  4'b0000, "irq_low1");
    tick(1);
    irq_ack = 4'h0;
`endif
    tb_val = 4'b0001;
    expect_at(6, K_FALL, 4'b0100, "io2_fall");
    expect_at(6, K_ST,   4'b0001, "io2_state_lo");
    expect_at(7, K_FALL, 4'b0000, "io2_fall_one_cycle");
    tick(6);
`ifdef IO_IRQ_EN
    irq_ack = 4'b0100;
    expect_at(1, K_IRQS, 4'b0100, "irq_ack_collide");
    expect_at(1, K_IRQ,  4'b0001, "irq_high_fall");
    tick(1);
    irq_ack = 4'b0100;
    expect_at(1, K_IRQS, 4'b0000, "irq_ack_clean2");
    expect_at(1, K_IRQ,  4'b0000, "irq_low2");
    tick(1);
    irq_ack = 4'h0;
`endif
    tick(4);

    while (sb.size() > 0) begin
      n_checks++;
      $display("FAIL %s: never sampled, got nothing expected %b", sb[0].name, sb[0].val);
      sb.delete(0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
